fetch_stage: RTL and testbench

//   Instruction-fetch (IF) stage of the 5-stage ARM pipeline. Owns the PC and drives the

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage_pc_register.sv | 21 ++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants, IF/ID bundle type and alignment helper.
// Imported by the fetch_stage interface, sub-module and top.
package fetch_stage_pkg;

    localparam logic [31:0] INSTRUCTION_LEN = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_ENC         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: word address and read strobe out, word back.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [31:0] inst_address;
    logic        inst_mem_read;
    logic [31:0] inst_data;

    modport master (
        output inst_address,
        output inst_mem_read,
        input  inst_data
    );

    modport slave (
        input  inst_address,
        input  inst_mem_read,
        output inst_data
    );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: 32-bit register with sync active-high reset and load enable.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PC, drives instruction memory, fills the IF/ID register.
// Optional perf counters under `ifdef FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_ENC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          branch_taken,
    input  logic [31:0]   branch_address,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]   fetch_count,
    output logic [31:0]   flush_count,
`endif
    output logic          if_id_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_load;
    if_id_t      if_id_q;

    localparam if_id_t BUBBLE = '{pc: 32'h0, inst: NOP_WORD, valid: 1'b0};

    assign pc_plus4 = pc + INSTRUCTION_LEN;

    // A redirect wins over a hazard freeze.
    always_comb begin
        pc_next = pc_plus4;
        pc_load = 1'b1;
        priority case (1'b1)
            branch_taken: pc_next = word_align(branch_address);
            freeze:       pc_load = 1'b0;
            default:      ;
        endcase
    end

    pc_register #(
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            if_id_q <= BUBBLE;
        else if (branch_taken)
            if_id_q <= BUBBLE;
        else if (!freeze)
            if_id_q <= '{pc: pc_plus4, inst: imem.inst_data, valid: 1'b1};
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else if (branch_taken) begin
            flush_count <= flush_count + 32'd1;
        end else if (!freeze) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

    assign imem.inst_address  = pc;
    assign imem.inst_mem_read = ~rst;

    assign if_id_pc    = if_id_q.pc;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push expected state,
// a monitor compares after each posedge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
        logic        rd;
        logic [31:0] fcnt;
        logic [31:0] lcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    fetch_stage_if bus ();

    // Memory word at address A is {16'hE000, A[15:0]}.
    assign bus.inst_data = {16'hE000, bus.inst_address[15:0]};

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem           (bus),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .flush_count    (flush_count),
`endif
        .if_id_valid    (if_id_valid)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    exp_t sb[$];
    int   applied = 0;
    int   errors = 0;
    bit   done = 1'b0;

    task automatic add(input logic r, input logic f, input logic b,
                       input logic [31:0] t, input logic [31:0] p,
                       input logic [31:0] ip, input logic [31:0] in,
                       input logic v);
        vec_t x;
        x.rst = r; x.frz = f; x.br = b; x.tgt = t;
        x.pc = p; x.ifpc = ip; x.inst = in; x.valid = v;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec%0d: got %h want %h", name, applied, act, req);
        end
    endtask

    initial begin
        // rst frz br tgt          pc            ifpc          inst          v
        add(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h4,        32'h4,        32'hE000_0000, 1);
        add(0, 0, 0, 32'h0,        32'h8,        32'h8,        32'hE000_0004, 1);
        add(0, 1, 0, 32'h0,        32'h8,        32'h8,        32'hE000_0004, 1);
        add(0, 1, 0, 32'h0,        32'h8,        32'h8,        32'hE000_0004, 1);
        add(0, 0, 0, 32'h0,        32'hC,        32'hC,        32'hE000_0008, 1);
        add(0, 0, 0, 32'h0,        32'h10,       32'h10,       32'hE000_000C, 1);
        add(0, 0, 0, 32'h0,        32'h14,       32'h14,       32'hE000_0010, 1);
        add(0, 0, 0, 32'h0,        32'h18,       32'h18,       32'hE000_0014, 1);
        add(0, 0, 0, 32'h0,        32'h1C,       32'h1C,       32'hE000_0018, 1);
        add(0, 0, 0, 32'h0,        32'h20,       32'h20,       32'hE000_001C, 1);
        add(0, 0, 1, 32'h98,       32'h98,       32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h9C,       32'h9C,       32'hE000_0098, 1);
        add(0, 1, 1, 32'h101,      32'h100,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h104,      32'h104,      32'hE000_0100, 1);
        add(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,      32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hE000_FFFC, 1);
        add(0, 0, 0, 32'h0,        32'h4,        32'h4,        32'hE000_0000, 1);
        add(0, 0, 1, 32'h3E,       32'h3C,       32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h40,       32'h40,       32'hE000_003C, 1);
        add(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h4,        32'h4,        32'hE000_0000, 1);
        add(0, 1, 0, 32'h0,        32'h4,        32'h4,        32'hE000_0000, 1);
        add(1, 1, 1, 32'h80,       32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        32'h4,        32'h4,        32'hE000_0000, 1);
    end

    initial begin : stim
        logic [31:0] fc = 0;
        logic [31:0] lc = 0;
        exp_t e;
        #1;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            freeze         = vecs[i].frz;
            branch_taken   = vecs[i].br;
            branch_address = vecs[i].tgt;
            if (vecs[i].rst) begin
                fc = 0; lc = 0;
            end else if (vecs[i].br) begin
                lc = lc + 1;
            end else if (!vecs[i].frz) begin
                fc = fc + 1;
            end
            e.pc = vecs[i].pc; e.ifpc = vecs[i].ifpc;
            e.inst = vecs[i].inst; e.valid = vecs[i].valid;
            e.rd = ~vecs[i].rst; e.fcnt = fc; e.lcnt = lc;
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 0; freeze = 1; branch_taken = 0;
        for (int k = 0; k < 20 && sb.size() != 0; k++)
            @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        if (applied != vecs.size()) begin
            errors++;
            $display("FAIL count: applied %0d want %0d", applied, vecs.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done && sb.size() != 0) begin
                e = sb.pop_front();
                chk("inst_address", bus.inst_address, e.pc);
                chk("if_id_pc", if_id_pc, e.ifpc);
                chk("if_id_inst", if_id_inst, e.inst);
                chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
                chk("inst_mem_read", {31'h0, bus.inst_mem_read}, {31'h0, e.rd});
`ifdef FETCH_PERF_CNT_EN
                chk("fetch_count", fetch_count, e.fcnt);
                chk("flush_count", flush_count, e.lcnt);
`endif
                applied++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: applied %0d want %0d", applied, vecs.size());
        $fatal(1, "timeout");
    end

endmodule
